// File: rtl/decode_stage_hz_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_hz_if
// Brief    : Bus bundle between the F/D register, writeback, the decode stage
//            and the execute stage (D inputs, W inputs, E outputs).
// Revision : 1.0 - initial release
// ============================================================================
interface decode_stage_hz_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
);
  // D-stage instruction and decoded side-band
  logic              valid_d_i;
  logic [31:0]       instr_d_i;
  logic [XLEN-1:0]   pc_d_i;
  logic [CTRL_W-1:0] ctrl_d_i;
  logic [XLEN-1:0]   imm_d_i;
  // Writeback port into the register file
  logic              reg_write_w_i;
  logic [4:0]        rd_w_i;
  logic [XLEN-1:0]   result_w_i;
  // Squash from E
  logic              flush_e_i;
  // Stall back to fetch and the D->E register contents
  logic              stall_d_o;
  logic              valid_e_o;
  logic [CTRL_W-1:0] ctrl_e_o;
  logic [XLEN-1:0]   pc_e_o;
  logic [XLEN-1:0]   rd1_e_o;
  logic [XLEN-1:0]   rd2_e_o;
  logic [XLEN-1:0]   imm_e_o;
  logic [4:0]        rd_e_o;
  logic [4:0]        rs1_e_o;
  logic [4:0]        rs2_e_o;
  logic [XLEN-1:0]   a0_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output valid_d_i, instr_d_i, pc_d_i, ctrl_d_i, imm_d_i,
    output reg_write_w_i, rd_w_i, result_w_i, flush_e_i,
    input  stall_d_o, valid_e_o, ctrl_e_o, pc_e_o, rd1_e_o, rd2_e_o,
    input  imm_e_o, rd_e_o, rs1_e_o, rs2_e_o, a0_o, stall_cnt_o
  );

  modport slave (
    input  valid_d_i, instr_d_i, pc_d_i, ctrl_d_i, imm_d_i,
    input  reg_write_w_i, rd_w_i, result_w_i, flush_e_i,
    output stall_d_o, valid_e_o, ctrl_e_o, pc_e_o, rd1_e_o, rd2_e_o,
    output imm_e_o, rd_e_o, rs1_e_o, rs2_e_o, a0_o, stall_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage_hz.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_hz
// Brief    : RV32I decode stage: register file with write-through bypass,
//            load-use hazard detection/stall, and the D->E pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage_hz #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int CTRL_W   = 12,
  parameter int LOAD_BIT = 0,
  parameter int CNT_W    = 16
) (
  input wire               clk,
  input wire               rst_n,
  decode_stage_hz_if.slave bus
);
  localparam int ADDR_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_REG    = 7'b0110011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

  logic [XLEN-1:0]   r_regs [NREGS];

  logic [6:0]        w_opcode;
  logic [4:0]        w_rs1;
  logic [4:0]        w_rs2;
  logic [4:0]        w_rd;
  logic              w_rs1_ok;
  logic              w_rs2_ok;
  logic              w_we;
  logic              w_use_rs1;
  logic              w_use_rs2;
  logic              w_hz;
  logic              w_stall;
  logic [XLEN-1:0]   w_rd1;
  logic [XLEN-1:0]   w_rd2;
  logic              w_unused;

  logic              r_valid_e;
  logic [CTRL_W-1:0] r_ctrl_e;
  logic [XLEN-1:0]   r_pc_e;
  logic [XLEN-1:0]   r_rd1_e;
  logic [XLEN-1:0]   r_rd2_e;
  logic [XLEN-1:0]   r_imm_e;
  logic [4:0]        r_rd_e;
  logic [4:0]        r_rs1_e;
  logic [4:0]        r_rs2_e;
  logic [CNT_W-1:0]  r_stall_cnt;

  // Field extraction, index legality and source-usage decode
  always_comb begin
    w_opcode  = bus.instr_d_i[6:0];
    w_rd      = bus.instr_d_i[11:7];
    w_rs1     = bus.instr_d_i[19:15];
    w_rs2     = bus.instr_d_i[24:20];
    w_rs1_ok  = (w_rs1 != 5'd0) && (32'(w_rs1) < 32'(NREGS));
    w_rs2_ok  = (w_rs2 != 5'd0) && (32'(w_rs2) < 32'(NREGS));
    w_we      = bus.reg_write_w_i && (bus.rd_w_i != 5'd0) &&
                (32'(bus.rd_w_i) < 32'(NREGS));
    w_use_rs1 = !((w_opcode == c_OP_LUI) || (w_opcode == c_OP_AUIPC) ||
                  (w_opcode == c_OP_JAL));
    w_use_rs2 = (w_opcode == c_OP_REG) || (w_opcode == c_OP_STORE) ||
                (w_opcode == c_OP_BRANCH);
  end

  // Opcode funct bits are decoded by the external control decoder
  assign w_unused = &{1'b0, bus.instr_d_i[31:25], bus.instr_d_i[14:12]};

  // Register-file write port; x0 and out-of-range targets never reach here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_we) begin
      r_regs[bus.rd_w_i[ADDR_W-1:0]] <= bus.result_w_i;
    end
  end

  // Read port 1 with same-cycle writeback bypass
  always_comb begin
    w_rd1 = '0;
    if (w_rs1_ok) begin
      if (w_we && (bus.rd_w_i == w_rs1)) w_rd1 = bus.result_w_i;
      else                               w_rd1 = r_regs[w_rs1[ADDR_W-1:0]];
    end
  end

  // Read port 2 with same-cycle writeback bypass
  always_comb begin
    w_rd2 = '0;
    if (w_rs2_ok) begin
      if (w_we && (bus.rd_w_i == w_rs2)) w_rd2 = bus.result_w_i;
      else                               w_rd2 = r_regs[w_rs2[ADDR_W-1:0]];
    end
  end

  // Load-use hazard; a flush wins because D is about to be squashed anyway
  always_comb begin
    w_hz = bus.valid_d_i && r_valid_e && r_ctrl_e[LOAD_BIT] &&
           (r_rd_e != 5'd0) &&
           ((w_use_rs1 && (r_rd_e == w_rs1)) ||
            (w_use_rs2 && (r_rd_e == w_rs2)));
    w_stall = w_hz && !bus.flush_e_i;
  end

  // D->E register: bubble on flush, stall or empty D, else capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_e <= 1'b0;
      r_ctrl_e  <= '0;
      r_pc_e    <= '0;
      r_rd1_e   <= '0;
      r_rd2_e   <= '0;
      r_imm_e   <= '0;
      r_rd_e    <= '0;
      r_rs1_e   <= '0;
      r_rs2_e   <= '0;
    end else if (bus.flush_e_i || w_stall || !bus.valid_d_i) begin
      r_valid_e <= 1'b0;
      r_ctrl_e  <= '0;
      r_pc_e    <= '0;
      r_rd1_e   <= '0;
      r_rd2_e   <= '0;
      r_imm_e   <= '0;
      r_rd_e    <= '0;
      r_rs1_e   <= '0;
      r_rs2_e   <= '0;
    end else begin
      r_valid_e <= 1'b1;
      r_ctrl_e  <= bus.ctrl_d_i;
      r_pc_e    <= bus.pc_d_i;
      r_rd1_e   <= w_rd1;
      r_rd2_e   <= w_rd2;
      r_imm_e   <= bus.imm_d_i;
      r_rd_e    <= w_rd;
      r_rs1_e   <= w_rs1;
      r_rs2_e   <= w_rs2;
    end
  end

  // Saturating count of load-use stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // a0 debug tap reads the array directly, so it lags a write by one cycle
  generate
    if (NREGS > 10) begin : g_a0
      assign bus.a0_o = r_regs[10];
    end else begin : g_no_a0
      assign bus.a0_o = '0;
    end
  endgenerate

  assign bus.stall_d_o   = w_stall;
  assign bus.valid_e_o   = r_valid_e;
  assign bus.ctrl_e_o    = r_ctrl_e;
  assign bus.pc_e_o      = r_pc_e;
  assign bus.rd1_e_o     = r_rd1_e;
  assign bus.rd2_e_o     = r_rd2_e;
  assign bus.imm_e_o     = r_imm_e;
  assign bus.rd_e_o      = r_rd_e;
  assign bus.rs1_e_o     = r_rs1_e;
  assign bus.rs2_e_o     = r_rs2_e;
  assign bus.stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_hz.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage_hz
// Brief    : Scoreboard bench for decode_stage_hz (NREGS=16, CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage_hz;
  localparam int XLEN     = 32;
  localparam int NREGS    = 16;
  localparam int CTRL_W   = 12;
  localparam int LOAD_BIT = 0;
  localparam int CNT_W    = 2;

  localparam logic [6:0]  c_OP_REG   = 7'b0110011;
  localparam logic [6:0]  c_OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  c_OP_STORE = 7'b0100011;
  localparam logic [6:0]  c_OP_IMM   = 7'b0010011;
  localparam logic [6:0]  c_OP_LUI   = 7'b0110111;
  localparam logic [11:0] c_ALU      = 12'h0A4;
  localparam logic [11:0] c_LD       = 12'h081;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_stage_hz_if #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  decode_stage_hz #(
    .XLEN(XLEN), .NREGS(NREGS), .CTRL_W(CTRL_W),
    .LOAD_BIT(LOAD_BIT), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       pc;
    logic [31:0]       rd1;
    logic [31:0]       rd2;
    logic [31:0]       imm;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    bus.reg_write_w_i = 1'b1;
    bus.rd_w_i        = rd;
    bus.result_w_i    = d;
  endtask

  // Present one D instruction for one cycle; queue its E image if it should be captured
  task automatic issue(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [11:0] ctrl, input logic [31:0] imm,
                       input logic [31:0] e1, input logic [31:0] e2, input logic exp_stall);
    exp_t e;
    bus.valid_d_i = v;
    bus.instr_d_i = ins;
    bus.pc_d_i    = pc;
    bus.ctrl_d_i  = ctrl;
    bus.imm_d_i   = imm;
    #1;
    chk("stall_d", 32'(bus.stall_d_o), 32'(exp_stall));
    if (v && !exp_stall && !bus.flush_e_i) begin
      e.ctrl = ctrl; e.pc = pc; e.rd1 = e1; e.rd2 = e2; e.imm = imm;
      e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
      q.push_back(e);
    end
    @(posedge clk); #1;
    bus.valid_d_i     = 1'b0;
    bus.reg_write_w_i = 1'b0;
    bus.flush_e_i     = 1'b0;
  endtask

  task automatic chk_bubble(input logic [31:0] cnt);
    chk("bubble_valid", 32'(bus.valid_e_o), 32'd0);
    chk("bubble_ctrl", 32'(bus.ctrl_e_o), 32'd0);
    chk("stall_cnt", 32'(bus.stall_cnt_o), cnt);
  endtask

  // Monitor: every valid E slot must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && bus.valid_e_o === 1'b1) begin
      if (q.size() == 0) begin
        chk("e_unexpected_valid", 32'(q.size()), 32'd1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("e_ctrl", 32'(bus.ctrl_e_o), 32'(e.ctrl));
        chk("e_pc",   bus.pc_e_o,  e.pc);
        chk("e_rd1",  bus.rd1_e_o, e.rd1);
        chk("e_rd2",  bus.rd2_e_o, e.rd2);
        chk("e_imm",  bus.imm_e_o, e.imm);
        chk("e_rd",   32'(bus.rd_e_o),  32'(e.rd));
        chk("e_rs1",  32'(bus.rs1_e_o), 32'(e.rs1));
        chk("e_rs2",  32'(bus.rs2_e_o), 32'(e.rs2));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.valid_d_i = 0; bus.instr_d_i = 0; bus.pc_d_i = 0; bus.ctrl_d_i = 0;
    bus.imm_d_i = 0; bus.reg_write_w_i = 0; bus.rd_w_i = 0; bus.result_w_i = 0;
    bus.flush_e_i = 0;

    // Reset with random activity on every input
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      bus.valid_d_i = 1'($urandom); bus.instr_d_i = $urandom; bus.pc_d_i = $urandom;
      bus.ctrl_d_i = 12'($urandom); bus.imm_d_i = $urandom;
      bus.reg_write_w_i = 1'($urandom); bus.rd_w_i = 5'($urandom);
      bus.result_w_i = $urandom; bus.flush_e_i = 1'($urandom);
    end
    #1;
    chk("rst_valid", 32'(bus.valid_e_o), 0);
    chk("rst_ctrl", 32'(bus.ctrl_e_o), 0);
    chk("rst_pc", bus.pc_e_o, 0);
    chk("rst_rd1", bus.rd1_e_o, 0);
    chk("rst_rd2", bus.rd2_e_o, 0);
    chk("rst_imm", bus.imm_e_o, 0);
    chk("rst_rd", 32'(bus.rd_e_o), 0);
    chk("rst_stall_cnt", 32'(bus.stall_cnt_o), 0);
    chk("rst_a0", bus.a0_o, 0);
    chk("rst_stall_d", 32'(bus.stall_d_o), 0);
    bus.valid_d_i = 0; bus.reg_write_w_i = 0; bus.flush_e_i = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // x5 reads zero after reset
    issue(1, mk(c_OP_REG, 6, 5, 0), 32'h100, c_ALU, 32'h11, 32'h0, 32'h0, 0);
    // Write-through of x5 into the same-cycle read
    wb(5, 32'hDEADBEEF);
    issue(1, mk(c_OP_REG, 6, 5, 0), 32'h104, c_ALU, 32'h22, 32'hDEADBEEF, 32'h0, 0);
    // Stored value on port 2
    issue(1, mk(c_OP_REG, 6, 0, 5), 32'h108, c_ALU, 32'h0, 32'h0, 32'hDEADBEEF, 0);
    wb(2, 32'h22);
    issue(0, 32'h0, 32'h0, 12'h0, 32'h0, 32'h0, 32'h0, 0);

    // Load-use on rs1: one stall, bubble, then capture (x7 arrives via bypass)
    issue(1, mk(c_OP_LOAD, 7, 1, 0), 32'h10C, c_LD, 32'h0, 32'h0, 32'h0, 0);
    issue(1, mk(c_OP_REG, 8, 7, 2), 32'h110, c_ALU, 32'h0, 32'h0, 32'h0, 1);
    chk_bubble(1);
    wb(7, 32'h77);
    issue(1, mk(c_OP_REG, 8, 7, 2), 32'h110, c_ALU, 32'h0, 32'h77, 32'h22, 0);
    // LUI whose rs1 field names the load target: no stall
    issue(1, mk(c_OP_LOAD, 7, 1, 0), 32'h114, c_LD, 32'h0, 32'h0, 32'h0, 0);
    issue(1, mk(c_OP_LUI, 9, 7, 0), 32'h118, c_ALU, 32'h7000, 32'h77, 32'h0, 0);
    chk("cnt_after_lui", 32'(bus.stall_cnt_o), 1);
    // Store uses rs2: stall
    issue(1, mk(c_OP_LOAD, 7, 1, 0), 32'h11C, c_LD, 32'h0, 32'h0, 32'h0, 0);
    issue(1, mk(c_OP_STORE, 0, 4, 7), 32'h120, c_ALU, 32'h4, 32'h0, 32'h0, 1);
    chk_bubble(2);
    issue(1, mk(c_OP_STORE, 0, 4, 7), 32'h120, c_ALU, 32'h4, 32'h0, 32'h77, 0);
    // OP-IMM ignores its rs2 field: no stall
    issue(1, mk(c_OP_LOAD, 7, 1, 0), 32'h124, c_LD, 32'h0, 32'h0, 32'h0, 0);
    issue(1, mk(c_OP_IMM, 9, 0, 7), 32'h128, c_ALU, 32'h0, 32'h0, 32'h77, 0);
    // Load to x0 never stalls
    issue(1, mk(c_OP_LOAD, 0, 1, 0), 32'h12C, c_LD, 32'h0, 32'h0, 32'h0, 0);
    issue(1, mk(c_OP_REG, 8, 0, 0), 32'h130, c_ALU, 32'h0, 32'h0, 32'h0, 0);
    chk("cnt_after_x0_load", 32'(bus.stall_cnt_o), 2);

    // Flush masks the hazard and bubbles E
    issue(1, mk(c_OP_LOAD, 3, 1, 0), 32'h134, c_LD, 32'h0, 32'h0, 32'h0, 0);
    bus.flush_e_i = 1'b1;
    issue(1, mk(c_OP_REG, 8, 3, 3), 32'h138, c_ALU, 32'h0, 32'h0, 32'h0, 0);
    chk_bubble(2);

    // x0 and out-of-range writes are dropped (x20 must not alias x4)
    wb(0, 32'h5);
    issue(0, 32'h0, 32'h0, 12'h0, 32'h0, 32'h0, 32'h0, 0);
    wb(20, 32'h9);
    issue(0, 32'h0, 32'h0, 12'h0, 32'h0, 32'h0, 32'h0, 0);
    wb(20, 32'h99);
    issue(1, mk(c_OP_REG, 8, 0, 20), 32'h13C, c_ALU, 32'h0, 32'h0, 32'h0, 0);
    issue(1, mk(c_OP_REG, 8, 4, 0), 32'h140, c_ALU, 32'h0, 32'h0, 32'h0, 0);
    wb(15, 32'h1234);
    issue(0, 32'h0, 32'h0, 12'h0, 32'h0, 32'h0, 32'h0, 0);
    issue(1, mk(c_OP_REG, 8, 15, 0), 32'h144, c_ALU, 32'h0, 32'h1234, 32'h0, 0);
    // a0 follows the array one cycle after the write
    wb(10, 32'h42);
    chk("a0_before", bus.a0_o, 32'h0);
    issue(0, 32'h0, 32'h0, 12'h0, 32'h0, 32'h0, 32'h0, 0);
    chk("a0_after", bus.a0_o, 32'h42);

    // Reset asserted mid-stall drops the stall immediately
    issue(1, mk(c_OP_LOAD, 7, 1, 0), 32'h148, c_LD, 32'h0, 32'h0, 32'h0, 0);
    @(negedge clk); #1;
    bus.valid_d_i = 1'b1;
    bus.instr_d_i = mk(c_OP_REG, 8, 7, 0);
    #1;
    chk("midstall_stall_on", 32'(bus.stall_d_o), 1);
    rst_n = 1'b0;
    #1;
    chk("midstall_stall_off", 32'(bus.stall_d_o), 0);
    chk("midstall_valid", 32'(bus.valid_e_o), 0);
    chk("midstall_cnt", 32'(bus.stall_cnt_o), 0);
    chk("midstall_a0", bus.a0_o, 0);
    @(posedge clk); #1;
    bus.valid_d_i = 1'b0;
    rst_n = 1'b1;

    // Back-to-back load/use pairs saturate the 2-bit counter
    for (int k = 0; k < 5; k++) begin
      issue(1, mk(c_OP_LOAD, 7, 1, 0), 32'h200 + 32'(k * 16), c_LD, 32'h0, 32'h0, 32'h0, 0);
      issue(1, mk(c_OP_REG, 8, 7, 0), 32'h204 + 32'(k * 16), c_ALU, 32'h0, 32'h0, 32'h0, 1);
      chk_bubble((k < 3) ? 32'(k + 1) : 32'd3);
      issue(1, mk(c_OP_REG, 8, 7, 0), 32'h204 + 32'(k * 16), c_ALU, 32'h0, 32'h0, 32'h0, 0);
    end

    @(negedge clk); #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
